// File: rtl/bt_cmd_scheduler_if.sv
// Bluetooth command scheduler bus.
// Bundles the UART receive strobe, the player step/volume handshake, the
// status-byte transmit handshake and the BUSY/OVF status flags.
// The slave modport is the scheduler's view. The master modport is the
// view of whatever drives the scheduler, such as the UART/player glue or a bench.
//   rx_valid/rx_data   : received command byte strobe
//   cur_track          : player's current track index
//   step_ack           : player finished the last step (strobe)
//   step_prev/next     : one-cycle step requests
//   vol_up/vol_down    : one-cycle volume pulses
//   tx_valid/tx_data   : status byte, held until tx_ready
//   busy               : scheduler executing a command
//   ovf                : valid byte dropped on a full queue
interface bt_cmd_scheduler_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [2:0] cur_track;
  logic       step_ack;
  logic       step_prev;
  logic       step_next;
  logic       vol_up;
  logic       vol_down;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       ovf;

  modport slave (
    input  rx_valid, rx_data, cur_track, step_ack, tx_ready,
    output step_prev, step_next, vol_up, vol_down, tx_valid, tx_data, busy, ovf
  );

  modport master (
    output rx_valid, rx_data, cur_track, step_ack, tx_ready,
    input  step_prev, step_next, vol_up, vol_down, tx_valid, tx_data, busy, ovf
  );
endinterface

// File: rtl/bt_cmd_scheduler.sv
// Bluetooth UART command scheduler.
// Queues command bytes 0x01..0x0B. Each byte is executed as one of the following:
//   * a single PREV/NEXT step (0x01/0x02)
//   * a volume pulse followed by an idle gap (0x03/0x04)
//   * an absolute track select (0x05..0x0B), expanded into |target-cur| steps
// The player acknowledges every step.
// Exactly one status byte {A|E, cmd[3:0]} is returned per executed command.
// Ports:
//   clk_i    : system clock
//   rst_n_i  : synchronous reset, active-low
//   bus      : bt_cmd_scheduler_if.slave (see interface header)
module bt_cmd_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter int VOL_GAP     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  bt_cmd_scheduler_if.slave bus
);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (ACK_TIMEOUT > VOL_GAP) ? ACK_TIMEOUT : VOL_GAP;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(VOL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_STEP     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_VOL      = 3'd4,
    S_GAP      = 3'd5,
    S_REPLY    = 3'd6
  } state_e;

  // Status byte: high nibble says ok (A) or error (E), low nibble echoes the command.
  function automatic logic [7:0] status_byte(input logic ok, input logic [3:0] code);
    return {(ok ? 4'hA : 4'hE), code};
  endfunction

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          ovf_q;

  state_e        state_q;
  logic [7:0]    cmd_q;
  logic [2:0]    steps_q;
  logic          dir_next_q;
  logic [TW-1:0] timer_q;
  logic          step_prev_q;
  logic          step_next_q;
  logic          vol_up_q;
  logic          vol_down_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic          busy_q;

  logic       byte_ok_s;
  logic       full_s;
  logic       pop_s;
  logic       push_s;
  logic       drop_s;
  logic [2:0] target_s;

  assign byte_ok_s = bus.rx_valid && (bus.rx_data >= 8'h01) && (bus.rx_data <= 8'h0B);
  assign full_s    = (count_q == DEPTH_C);
  assign pop_s     = (state_q == S_IDLE) && (count_q != {(PW+1){1'b0}});
  // A pop in the same cycle frees a slot, so a push onto a full queue still succeeds.
  assign push_s    = byte_ok_s && (!full_s || pop_s);
  assign drop_s    = byte_ok_s && full_s && !pop_s;
  // 3-bit wrap is intended: 0x05..0x0B map to targets 0..6.
  assign target_s  = cmd_q[2:0] - 3'd5;

  assign bus.step_prev = step_prev_q;
  assign bus.step_next = step_next_q;
  assign bus.vol_up    = vol_up_q;
  assign bus.vol_down  = vol_down_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;

  // Queue storage: written on every accepted push, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= bus.rx_data;
    end
  end

  // Queue pointers, occupancy and overflow pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= drop_s;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Command FSM. Pulse outputs are set on the edge that enters STEP/VOL,
  // so each pulse is high exactly while the FSM sits in that state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'h00;
      steps_q     <= 3'd0;
      dir_next_q  <= 1'b0;
      timer_q     <= {TW{1'b0}};
      step_prev_q <= 1'b0;
      step_next_q <= 1'b0;
      vol_up_q    <= 1'b0;
      vol_down_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      step_prev_q <= 1'b0;
      step_next_q <= 1'b0;
      vol_up_q    <= 1'b0;
      vol_down_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            cmd_q   <= fifo_q[rd_ptr_q];
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        // cur_track is only looked at here; later changes do not affect the step count.
        S_FETCH: begin
          case (cmd_q)
            8'h01: begin
              steps_q     <= 3'd1;
              dir_next_q  <= 1'b0;
              step_prev_q <= 1'b1;
              state_q     <= S_STEP;
            end
            8'h02: begin
              steps_q     <= 3'd1;
              dir_next_q  <= 1'b1;
              step_next_q <= 1'b1;
              state_q     <= S_STEP;
            end
            8'h03: begin
              vol_up_q <= 1'b1;
              state_q  <= S_VOL;
            end
            8'h04: begin
              vol_down_q <= 1'b1;
              state_q    <= S_VOL;
            end
            8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B: begin
              if (target_s == bus.cur_track) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= status_byte(1'b1, cmd_q[3:0]);
                state_q    <= S_REPLY;
              end else if (target_s > bus.cur_track) begin
                steps_q     <= target_s - bus.cur_track;
                dir_next_q  <= 1'b1;
                step_next_q <= 1'b1;
                state_q     <= S_STEP;
              end else begin
                steps_q     <= bus.cur_track - target_s;
                dir_next_q  <= 1'b0;
                step_prev_q <= 1'b1;
                state_q     <= S_STEP;
              end
            end
            default: begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= status_byte(1'b0, cmd_q[3:0]);
              state_q    <= S_REPLY;
            end
          endcase
        end
        S_STEP: begin
          timer_q <= {TW{1'b0}};
          state_q <= S_WAIT_ACK;
        end
        // An ack in the same cycle as the timeout still counts as an ack.
        S_WAIT_ACK: begin
          if (bus.step_ack) begin
            steps_q <= steps_q - 3'd1;
            if (steps_q == 3'd1) begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= status_byte(1'b1, cmd_q[3:0]);
              state_q    <= S_REPLY;
            end else begin
              step_next_q <= dir_next_q;
              step_prev_q <= !dir_next_q;
              state_q     <= S_STEP;
            end
          end else if (timer_q == ACK_LAST) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= status_byte(1'b0, cmd_q[3:0]);
            state_q    <= S_REPLY;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_VOL: begin
          timer_q <= {TW{1'b0}};
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (timer_q == GAP_LAST) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= status_byte(1'b1, cmd_q[3:0]);
            state_q    <= S_REPLY;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_REPLY: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bt_cmd_scheduler.sv
// Directed bench for bt_cmd_scheduler: a table of single commands with
// hand-computed pulse counts and status bytes, plus hand-written sequences
// for latency, TX hold, volume gap, queue overflow, ack timeout and reset.
module tb_bt_cmd_scheduler;
  localparam int FIFO_DEPTH  = 4;
  localparam int ACK_TIMEOUT = 1024;
  localparam int VOL_GAP     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bt_cmd_scheduler_if bus();

  bt_cmd_scheduler #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .VOL_GAP    (VOL_GAP)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [2:0] track;
    int         ack_dly;
    bit         chg;
    logic [2:0] track_after;
    logic [7:0] exp_tx;
    int         exp_np;
    int         exp_nn;
    int         exp_nu;
    int         exp_nd;
  } vec_t;

  vec_t vecs[9];
  int   n_vec = 0;
  int   n_err = 0;
  int   overlap = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  function automatic logic [7:0] outs_now();
    return {bus.step_prev, bus.step_next, bus.vol_up, bus.vol_down,
            bus.tx_valid, bus.busy, bus.ovf, |bus.tx_data};
  endfunction

  // Sends one command with tx_ready=1, acks each step after ack_dly cycles,
  // and compares pulse counts and the status byte.
  task automatic run_vec(input vec_t v, input int idx);
    int np = 0;
    int nn = 0;
    int nu = 0;
    int nd = 0;
    int ack_cnt = 0;
    logic [7:0] tx = 8'h00;
    bit got = 1'b0;
    bus.cur_track = v.track;
    send_byte(v.cmd);
    for (int i = 0; i < 400 && !got; i++) begin
      if (bus.step_prev) np++;
      if (bus.step_next) nn++;
      if (bus.vol_up) nu++;
      if (bus.vol_down) nd++;
      if ((bus.step_prev || bus.step_next) && (bus.vol_up || bus.vol_down)) overlap++;
      if (bus.tx_valid) begin
        tx  = bus.tx_data;
        got = 1'b1;
      end
      bus.step_ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) bus.step_ack = 1'b1;
      end
      if (bus.step_prev || bus.step_next) begin
        ack_cnt = v.ack_dly;
        if (v.chg) bus.cur_track = v.track_after;
      end
      tick();
    end
    bus.step_ack = 1'b0;
    check($sformatf("v%0d_done", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_tx", idx), 32'(tx), 32'(v.exp_tx));
    check($sformatf("v%0d_prev", idx), 32'(np), 32'(v.exp_np));
    check($sformatf("v%0d_next", idx), 32'(nn), 32'(v.exp_nn));
    check($sformatf("v%0d_up", idx), 32'(nu), 32'(v.exp_nu));
    check($sformatf("v%0d_down", idx), 32'(nd), 32'(v.exp_nd));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] txs[8];
    int ntx;
    int up_cyc;
    int dn_cyc;
    int pulse_cyc;
    int act;
    bit stable;
    bit got;

    //                cmd    trk  dly chg  after  tx     np nn nu nd
    vecs[0] = '{8'h02, 3'd0, 2, 1'b0, 3'd0, 8'hA2, 0, 1, 0, 0};
    vecs[1] = '{8'h01, 3'd0, 1, 1'b0, 3'd0, 8'hA1, 1, 0, 0, 0};
    vecs[2] = '{8'h0A, 3'd1, 3, 1'b1, 3'd4, 8'hAA, 0, 4, 0, 0};
    vecs[3] = '{8'h06, 3'd6, 1, 1'b0, 3'd0, 8'hA6, 5, 0, 0, 0};
    vecs[4] = '{8'h08, 3'd3, 1, 1'b0, 3'd0, 8'hA8, 0, 0, 0, 0};
    vecs[5] = '{8'h03, 3'd0, 1, 1'b0, 3'd0, 8'hA3, 0, 0, 1, 0};
    vecs[6] = '{8'h04, 3'd0, 1, 1'b0, 3'd0, 8'hA4, 0, 0, 0, 1};
    vecs[7] = '{8'h0B, 3'd0, 2, 1'b0, 3'd0, 8'hAB, 0, 6, 0, 0};
    vecs[8] = '{8'h05, 3'd7, 1, 1'b0, 3'd0, 8'hA5, 7, 0, 0, 0};

    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.cur_track = 3'd0;
    bus.step_ack  = 1'b0;
    bus.tx_ready  = 1'b1;
    rst_n = 1'b0;
    tick(); tick(); tick();
    check("reset_outputs", 32'(outs_now()), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end
    check("no_step_vol_overlap", 32'(overlap), 32'd0);

    // Latency and TX hold: pulse at t+3, ack at t+5, status held while not ready.
    bus.tx_ready  = 1'b0;
    bus.cur_track = 3'd2;
    send_byte(8'h02);
    check("lat_t1", 32'(bus.step_next), 32'd0);
    tick();
    check("lat_t2", 32'(bus.step_next), 32'd0);
    tick();
    check("lat_t3_pulse", 32'(bus.step_next), 32'd1);
    tick();
    check("pulse_one_cycle", 32'(bus.step_next), 32'd0);
    bus.step_ack = 1'b1;
    tick();
    bus.step_ack = 1'b0;
    check("reply_valid", 32'(bus.tx_valid), 32'd1);
    check("reply_data", 32'(bus.tx_data), 32'hA2);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA2) stable = 1'b0;
    end
    check("tx_hold_stable", 32'(stable), 32'd1);
    bus.tx_ready = 1'b1;
    tick();
    check("tx_accept_valid", 32'(bus.tx_valid), 32'd0);
    check("tx_accept_busy", 32'(bus.busy), 32'd0);

    // Back-to-back volume commands: gap between pulses at least VOL_GAP.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h03;
    tick();
    bus.rx_data  = 8'h04;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    up_cyc = -1000;
    dn_cyc = -1;
    ntx = 0;
    for (int i = 0; i < 200 && ntx < 2; i++) begin
      if (bus.vol_up) up_cyc = i;
      if (bus.vol_down) dn_cyc = i;
      if (bus.tx_valid) begin
        txs[ntx] = bus.tx_data;
        ntx++;
      end
      tick();
    end
    check("vol_tx_count", 32'(ntx), 32'd2);
    check("vol_tx0", 32'(txs[0]), 32'hA3);
    check("vol_tx1", 32'(txs[1]), 32'hA4);
    act = dn_cyc - up_cyc - 1;
    check("vol_gap_min", 32'(act >= VOL_GAP && up_cyc >= 0), 32'd1);

    // Overflow: one command in flight, four queued, fifth dropped.
    bus.tx_ready = 1'b0;
    send_byte(8'h03);
    tick(); tick();
    send_byte(8'h03); check("ovf_b1", 32'(bus.ovf), 32'd0);
    send_byte(8'h04); check("ovf_b2", 32'(bus.ovf), 32'd0);
    send_byte(8'h03); check("ovf_b3", 32'(bus.ovf), 32'd0);
    send_byte(8'h04); check("ovf_b4", 32'(bus.ovf), 32'd0);
    send_byte(8'h02); check("ovf_b5", 32'(bus.ovf), 32'd1);
    send_byte(8'h00); check("ignore_00", 32'(bus.ovf), 32'd0);
    send_byte(8'h20); check("ignore_20", 32'(bus.ovf), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.tx_valid) got = 1'b1;
      else tick();
    end
    check("ovf_first_reply", 32'(bus.tx_data), 32'hA3);
    bus.tx_ready = 1'b1;
    tick();
    // Queue is full and a pop happens in this IDLE cycle: push must succeed.
    send_byte(8'h04);
    check("push_on_pop", 32'(bus.ovf), 32'd0);
    ntx = 0;
    for (int i = 0; i < 400 && ntx < 6; i++) begin
      if (bus.tx_valid) begin
        txs[ntx] = bus.tx_data;
        ntx++;
      end
      tick();
    end
    check("drain_count", 32'(ntx), 32'd5);
    check("drain0", 32'(txs[0]), 32'hA3);
    check("drain1", 32'(txs[1]), 32'hA4);
    check("drain2", 32'(txs[2]), 32'hA3);
    check("drain3", 32'(txs[3]), 32'hA4);
    check("drain4", 32'(txs[4]), 32'hA4);

    // Ack timeout: no STEP_ACK, error reply after ACK_TIMEOUT cycles.
    send_byte(8'h01);
    pulse_cyc = -1;
    got = 1'b0;
    act = 0;
    for (int i = 0; i < 1200 && !got; i++) begin
      if (bus.step_prev) pulse_cyc = i;
      if (bus.tx_valid) begin
        got = 1'b1;
        txs[0] = bus.tx_data;
        act = i - pulse_cyc;
      end
      tick();
    end
    check("timeout_reply", 32'(got), 32'd1);
    check("timeout_data", 32'(txs[0]), 32'hE1);
    check("timeout_delay", 32'(act >= ACK_TIMEOUT && act <= ACK_TIMEOUT + 2 && pulse_cyc >= 0), 32'd1);

    // Reset mid-WAIT_ACK with commands still queued.
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h04);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.step_prev) got = 1'b1;
      tick();
    end
    check("rst_seq_pulse", 32'(got), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_outputs", 32'(outs_now()), 32'd0);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (outs_now() != 8'h00) act++;
    end
    check("rst_fifo_flushed", 32'(act), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
